// File: rtl/pcileech_eth_pkg.sv
// Shared types and constants for the Ethernet transmit scheduler.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pcileech_eth_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, WAIT3, SEND3} eth_tx_state_t;

  // Upper half of the optional per-packet tag DWORD
  localparam logic [15:0] ETH_TX_TAG_MAGIC = 16'h7A7A;

  // Width of the per-packet DWORD counter (holds 1..256)
  localparam int ETH_TX_DW_BITS = 9;

endpackage

// File: rtl/pcileech_eth_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last winner.
// Latency: grant is combinational from req; last_grant updates one cycle after upd.
// Backpressure: none; the caller decides when a grant is consumed via upd.
module pcileech_eth_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_grant,
  output logic       grant
);

  logic last_grant;

  // Prefer the source that did not win last time; otherwise take whichever asks
  always_comb begin
    grant = 1'b0;
    if (req[0] && req[1]) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

  // Remember the winner of the packet that just closed; reset favours s0 next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (upd) begin
      last_grant <= upd_grant;
    end
  end

endmodule

// File: rtl/pcileech_eth_tx_sched.sv
// Packetises two DWORD requesters into the UDP byte stream, MSB first, a whole packet per grant.
// Latency: DWORD accepted in IDLE appears as the first byte on the next cycle; >= 5 cycles per DWORD.
// Backpressure: tx_ready stalls the byte in flight; requesters stall until ready pulses. Macro PCILEECH_ETH_TX_TAG_EN prefixes a tag DWORD.
module pcileech_eth_tx_sched
  import pcileech_eth_pkg::*;
#(
  parameter int MAX_DW = 256,
  parameter int LINGER = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s0_data,
  input  logic        s0_valid,
  output logic        s0_ready,
  input  logic [31:0] s1_data,
  input  logic        s1_valid,
  output logic        s1_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic [15:0] pkt_cnt
);

  localparam logic [ETH_TX_DW_BITS-1:0] MAX_C    = ETH_TX_DW_BITS'(MAX_DW);
  localparam logic [7:0]                LINGER_C = 8'(LINGER);

  eth_tx_state_t             state;
  logic [31:0]               sh_buf;
  logic [31:0]               nxt_q;
  logic [1:0]                idx;
  logic [ETH_TX_DW_BITS-1:0] dw_cnt;
  logic [7:0]                linger_cnt;
  logic                      lastq;
  logic                      g_q;
  logic                      gnt;
  logic                      pkt_done;
  logic                      s_valid_g;
  logic [31:0]               s_data_g;

  // Granted requester's view, fixed for the whole packet
  assign s_valid_g = g_q ? s1_valid : s0_valid;
  assign s_data_g  = g_q ? s1_data  : s0_data;
  assign pkt_done  = (state == SEND3) && tx_ready && lastq;

  pcileech_eth_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({s1_valid, s0_valid}),
    .upd       (pkt_done),
    .upd_grant (g_q),
    .grant     (gnt)
  );

  // Byte interface is decoded from state only, so tx_valid never sees tx_ready
  assign tx_valid = (state == SHIFT) || (state == SEND3);
  assign tx_data  = tx_valid ? sh_buf[31:24] : 8'h00;
  assign tx_last  = (state == SEND3) && lastq;
  assign busy     = (state != IDLE);

  // Packet FSM: grant, shift three bytes, decide the fourth byte's fate, send it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh_buf     <= '0;
      nxt_q      <= '0;
      idx        <= '0;
      dw_cnt     <= '0;
      linger_cnt <= '0;
      lastq      <= 1'b0;
      g_q        <= 1'b0;
      s0_ready   <= 1'b0;
      s1_ready   <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      s0_ready <= 1'b0;
      s1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            g_q    <= gnt;
            dw_cnt <= 9'd1;
            idx    <= 2'd0;
            state  <= SHIFT;
`ifdef PCILEECH_ETH_TX_TAG_EN
            // Tag occupies the first DWORD slot; payload comes in through WAIT3
            sh_buf <= {ETH_TX_TAG_MAGIC, 8'h00, 7'b0, gnt};
`else
            sh_buf   <= gnt ? s1_data : s0_data;
            s0_ready <= ~gnt;
            s1_ready <= gnt;
`endif
          end
        end
        SHIFT: begin
          if (tx_ready) begin
            sh_buf <= {sh_buf[23:0], 8'h00};
            idx    <= idx + 1'b1;
            if (idx == 2'd2) begin
              linger_cnt <= '0;
              state      <= WAIT3;
            end
          end
        end
        WAIT3: begin
          // Hold the last byte back until we know whether it closes the packet
          if (dw_cnt == MAX_C) begin
            lastq <= 1'b1;
            state <= SEND3;
          end else if (s_valid_g) begin
            s0_ready <= ~g_q;
            s1_ready <= g_q;
            nxt_q    <= s_data_g;
            lastq    <= 1'b0;
            state    <= SEND3;
          end else if (linger_cnt == LINGER_C) begin
            lastq <= 1'b1;
            state <= SEND3;
          end else begin
            linger_cnt <= linger_cnt + 1'b1;
          end
        end
        SEND3: begin
          if (tx_ready) begin
            if (lastq) begin
              pkt_cnt <= pkt_cnt + 1'b1;
              state   <= IDLE;
            end else begin
              sh_buf <= nxt_q;
              dw_cnt <= dw_cnt + 1'b1;
              idx    <= 2'd0;
              state  <= SHIFT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcileech_eth_tx_sched.sv
// Directed bench: two scheduler instances (MAX_DW=256 and MAX_DW=2), byte scoreboard per requester.
// Latency: n/a.
// Backpressure: tx_ready driven from the stimulus sequence, randomised in one step.
module tb_pcileech_eth_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [31:0] a_s0_data, a_s1_data, b_s0_data, b_s1_data;
  logic        a_s0_valid, a_s1_valid, b_s0_valid, b_s1_valid;
  logic        a_s0_ready, a_s1_ready, b_s0_ready, b_s1_ready;
  logic [7:0]  a_tx_data, b_tx_data;
  logic        a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready, a_tx_last, b_tx_last;
  logic        a_busy, b_busy;
  logic [15:0] a_pkt_cnt, b_pkt_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp00[$], exp01[$], exp10[$], exp11[$];
  int         pk0[$], pk1[$];

  bit         mon_en [2];
  int         in_pkt [2], cur_src [2], cur_len [2], gap [2], last_gap [2];
  logic       stall_pend [2], stall_last [2];
  logic [7:0] stall_dat [2];
  bit         bp_done;

  always #5 clk = ~clk;

  pcileech_eth_tx_sched #(.MAX_DW(256), .LINGER(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s0_data(a_s0_data), .s0_valid(a_s0_valid), .s0_ready(a_s0_ready),
    .s1_data(a_s1_data), .s1_valid(a_s1_valid), .s1_ready(a_s1_ready),
    .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
    .tx_last(a_tx_last), .busy(a_busy), .pkt_cnt(a_pkt_cnt)
  );

  pcileech_eth_tx_sched #(.MAX_DW(2), .LINGER(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s0_data(b_s0_data), .s0_valid(b_s0_valid), .s0_ready(b_s0_ready),
    .s1_data(b_s1_data), .s1_valid(b_s1_valid), .s1_ready(b_s1_ready),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
    .tx_last(b_tx_last), .busy(b_busy), .pkt_cnt(b_pkt_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int inst, input int src, input logic v, input logic [31:0] d);
    case ({inst[0], src[0]})
      2'b00: begin a_s0_valid = v; a_s0_data = d; end
      2'b01: begin a_s1_valid = v; a_s1_data = d; end
      2'b10: begin b_s0_valid = v; b_s0_data = d; end
      default: begin b_s1_valid = v; b_s1_data = d; end
    endcase
  endtask

  function automatic logic get_rdy(input int inst, input int src);
    case ({inst[0], src[0]})
      2'b00:   return a_s0_ready;
      2'b01:   return a_s1_ready;
      2'b10:   return b_s0_ready;
      default: return b_s1_ready;
    endcase
  endfunction

  task automatic exp_push(input int inst, input int src, input logic [7:0] b);
    case ({inst[0], src[0]})
      2'b00:   exp00.push_back(b);
      2'b01:   exp01.push_back(b);
      2'b10:   exp10.push_back(b);
      default: exp11.push_back(b);
    endcase
  endtask

  task automatic exp_peek(input int inst, input int src, output int sz, output logic [7:0] f);
    f = 8'h00;
    case ({inst[0], src[0]})
      2'b00:   begin sz = exp00.size(); if (sz > 0) f = exp00[0]; end
      2'b01:   begin sz = exp01.size(); if (sz > 0) f = exp01[0]; end
      2'b10:   begin sz = exp10.size(); if (sz > 0) f = exp10[0]; end
      default: begin sz = exp11.size(); if (sz > 0) f = exp11[0]; end
    endcase
  endtask

  // Empty queue yields X so the following === comparison fails
  task automatic exp_pop(input int inst, input int src, output logic [7:0] e);
    e = 8'hxx;
    case ({inst[0], src[0]})
      2'b00:   if (exp00.size() > 0) e = exp00.pop_front();
      2'b01:   if (exp01.size() > 0) e = exp01.pop_front();
      2'b10:   if (exp10.size() > 0) e = exp10.pop_front();
      default: if (exp11.size() > 0) e = exp11.pop_front();
    endcase
  endtask

  function automatic int pk_size(input int inst);
    return (inst == 0) ? pk0.size() : pk1.size();
  endfunction

  // Present n DWORDs from one requester, holding each until it is accepted
  task automatic feed(input int inst, input int src, input int n,
                      input logic [31:0] base, input logic [31:0] step);
    logic [31:0] d;
    bit ok;
    for (int i = 0; i < n; i++) begin
      d = base + step * 32'(i);
      set_src(inst, src, 1'b1, d);
      for (int k = 0; k < 4; k++) exp_push(inst, src, d[31-8*k -: 8]);
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (get_rdy(inst, src)) begin ok = 1'b1; break; end
      end
      chk("accept", 32'(ok), 32'd1);
      if (!ok) break;
      @(posedge clk); #1;
    end
    set_src(inst, src, 1'b0, 32'h0);
  endtask

  task automatic wait_pk(input int inst, input int n, input int budget);
    for (int c = 0; c < budget && pk_size(inst) < n; c++) @(negedge clk);
    chk("wait_pkt", 32'(pk_size(inst) >= n), 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_pk(input int inst, input string tag, input int src, input int len);
    int got;
    got = -1;
    if (inst == 0 && pk0.size() > 0) got = pk0.pop_front();
    if (inst == 1 && pk1.size() > 0) got = pk1.pop_front();
    chk(tag, 32'(got), 32'(src * 65536 + len));
  endtask

  // Byte monitor: scoreboard compare, hold-while-stalled check, packet log
  task automatic mon(input int inst);
    logic v, r, l;
    logic [7:0] d, e, f;
    int sz;
    v = inst ? b_tx_valid : a_tx_valid;
    r = inst ? b_tx_ready : a_tx_ready;
    l = inst ? b_tx_last  : a_tx_last;
    d = inst ? b_tx_data  : a_tx_data;
    if (!mon_en[inst] || !rst_n) begin
      stall_pend[inst] = 1'b0;
      in_pkt[inst] = 0;
      return;
    end
    if (stall_pend[inst]) begin
      chk("hold_vld",  32'(v), 32'd1);
      chk("hold_dat",  32'(d), 32'(stall_dat[inst]));
      chk("hold_last", 32'(l), 32'(stall_last[inst]));
    end
    if (v && r) begin
      if (in_pkt[inst] == 0) begin
        exp_peek(inst, 0, sz, f);
        cur_src[inst] = (sz > 0 && f == d) ? 0 : 1;
        in_pkt[inst]  = 1;
        cur_len[inst] = 0;
      end
      exp_pop(inst, cur_src[inst], e);
      chk("byte", 32'(d), 32'(e));
      cur_len[inst]++;
      last_gap[inst] = gap[inst];
      gap[inst] = 0;
      if (l) begin
        if (inst == 0) pk0.push_back(cur_src[0] * 65536 + cur_len[0]);
        else           pk1.push_back(cur_src[1] * 65536 + cur_len[1]);
        in_pkt[inst] = 0;
      end
      stall_pend[inst] = 1'b0;
    end else begin
      if (!v) gap[inst]++;
      stall_pend[inst] = v;
      stall_dat[inst]  = d;
      stall_last[inst] = l;
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  initial begin
    bit ok;
    int sz;
    logic [7:0] f;
    rst_n = 1'b0;
    a_tx_ready = 1'b1; b_tx_ready = 1'b1;
    set_src(0, 0, 1'b0, 32'h0); set_src(0, 1, 1'b0, 32'h0);
    set_src(1, 0, 1'b0, 32'h0); set_src(1, 1, 1'b0, 32'h0);
    bp_done = 1'b0;
    mon_en[0] = 1'b0; mon_en[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx_valid", 32'(a_tx_valid), 32'd0);
    chk("rst_tx_last",  32'(a_tx_last),  32'd0);
    chk("rst_tx_data",  32'(a_tx_data),  32'd0);
    chk("rst_busy",     32'(a_busy),     32'd0);
    chk("rst_pkt_cnt",  32'(a_pkt_cnt),  32'd0);
    chk("rst_s0_ready", 32'(a_s0_ready), 32'd0);
    chk("rst_s1_ready", 32'(a_s1_ready), 32'd0);
    chk("rst_b_busy",   32'(b_busy),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted mid-packet clears the byte interface at once
    set_src(0, 0, 1'b1, 32'h5A5B5C5D);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_tx_valid) begin ok = 1'b1; break; end
    end
    chk("pre_rst_vld", 32'(ok), 32'd1);
    @(negedge clk);
    chk("pre_rst_busy", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_valid", 32'(a_tx_valid), 32'd0);
    chk("mid_rst_tx_data",  32'(a_tx_data),  32'd0);
    chk("mid_rst_tx_last",  32'(a_tx_last),  32'd0);
    chk("mid_rst_busy",     32'(a_busy),     32'd0);
    chk("mid_rst_s0_ready", 32'(a_s0_ready), 32'd0);
    set_src(0, 0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en[0] = 1'b1; mon_en[1] = 1'b1;

`ifdef PCILEECH_ETH_TX_TAG_EN
    // Tag DWORD precedes the payload; requester 1 gives tag low byte 01
    exp_push(0, 1, 8'h7A); exp_push(0, 1, 8'h7A);
    exp_push(0, 1, 8'h00); exp_push(0, 1, 8'h01);
    feed(0, 1, 1, 32'h11223344, 32'h0);
    wait_pk(0, 1, 200);
    chk_pk(0, "tag_pkt", 1, 8);
    chk("tag_pkt_cnt", 32'(a_pkt_cnt), 32'd1);
`else
    // Both valid after reset: s0 wins, then s1
    fork
      feed(0, 0, 1, 32'h30313233, 32'h0);
      feed(0, 1, 1, 32'h40414243, 32'h0);
    join
    wait_pk(0, 2, 200);
    chk_pk(0, "first_after_rst_s0", 0, 4);
    chk_pk(0, "second_after_rst_s1", 1, 4);
    chk("pkt_cnt_2", 32'(a_pkt_cnt), 32'd2);

    // Single DWORD, closed by linger: 17 idle cycles before the last byte
    feed(0, 0, 1, 32'hA1B2C3D4, 32'h0);
    wait_pk(0, 1, 200);
    chk_pk(0, "single_pkt", 0, 4);
    chk("single_gap", 32'(last_gap[0]), 32'd17);
    chk("pkt_cnt_3", 32'(a_pkt_cnt), 32'd3);

    // 300-DWORD stream splits at 256 DWORDs
    feed(0, 0, 300, 32'h01000000, 32'h00000001);
    wait_pk(0, 2, 400);
    chk_pk(0, "stream_pkt1", 0, 1024);
    chk_pk(0, "stream_pkt2", 0, 176);
    chk("pkt_cnt_5", 32'(a_pkt_cnt), 32'd5);

    // Random tx_ready backpressure over a counting byte pattern
    fork
      begin
        feed(0, 0, 8, 32'h00010203, 32'h04040404);
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          a_tx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    a_tx_ready = 1'b1;
    wait_pk(0, 1, 200);
    chk_pk(0, "bp_pkt", 0, 32);
    chk("pkt_cnt_6", 32'(a_pkt_cnt), 32'd6);

    // Round-robin with MAX_DW=2, both requesters always valid
    fork
      feed(1, 0, 6, 32'h10000000, 32'h1);
      feed(1, 1, 6, 32'h20000000, 32'h1);
    join
    wait_pk(1, 6, 200);
    for (int i = 0; i < 6; i++) chk_pk(1, "rr_pkt", i % 2, 8);
    chk("rr_pkt_cnt", 32'(b_pkt_cnt), 32'd6);
`endif

    // Everything presented was transmitted
    exp_peek(0, 0, sz, f); chk("left_a0", 32'(sz), 32'd0);
    exp_peek(0, 1, sz, f); chk("left_a1", 32'(sz), 32'd0);
    exp_peek(1, 0, sz, f); chk("left_b0", 32'(sz), 32'd0);
    exp_peek(1, 1, sz, f); chk("left_b1", 32'(sz), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
